pll_reset_sequencer: RTL and testbench

- Control stage directly upstream of a PLLE2_ADV instance.
- Drives the PLL's RST and CLKINSEL pins and supervises its LOCKED output. Provides a timed reset pulse, lock wait with timeout and retry, a lock-stability qualifier, lock-loss recovery, and a safe reset-wrapped input-clock switch.
- Its ready/reset outputs gate the counters and logic that consume the PLL clocks.

---
 rtl/pll_reset_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset/lock supervisor sitting in front of a PLLE2_ADV: timed RST pulse, lock wait with
// timeout/retry, lock-stability qualification, lock-loss recovery and reset-wrapped CLKINSEL switch.
module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 100000,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned MAX_RETRIES  = 0
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       I_CLKINSEL,
   input  logic       I_LOCKED,
   output logic       O_PLL_RST,
   output logic       O_CLKINSEL,
   output logic       O_READY,
   output logic       O_USER_RST,
   output logic       O_FAIL,
   output logic [7:0] O_RETRY_CNT,
   output logic [7:0] O_LOSS_CNT
);

   localparam int unsigned MaxA = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MaxT = (MaxA > LOCK_STABLE) ? MaxA : LOCK_STABLE;
   localparam int unsigned TW   = $clog2(MaxT + 1);

   localparam logic [TW-1:0] RstLast  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] ToLast   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] StbLast  = TW'(LOCK_STABLE - 1);
   localparam logic [TW-1:0] TimerOne = TW'(1);

   typedef enum logic [2:0] {
      StReset,
      StWaitLock,
      StStable,
      StRun,
      StFail
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          lk_meta_q, lk_s_q;
   logic          sel_meta_q, sel_s_q;
   logic          pll_rst_q, pll_rst_d;
   logic          clkinsel_q, clkinsel_d;
   logic          ready_q, ready_d;
   logic          user_rst_q;
   logic          fail_q, fail_d;
   logic [7:0]    retry_q, retry_d;
   logic [7:0]    loss_q, loss_d;
   logic [7:0]    retry_sat;
   logic [7:0]    loss_sat;

   assign retry_sat = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
   assign loss_sat  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      pll_rst_d  = pll_rst_q;
      clkinsel_d = clkinsel_q;
      ready_d    = ready_q;
      fail_d     = fail_q;
      retry_d    = retry_q;
      loss_d     = loss_q;

      // An input-clock change wraps the switch in a fresh PLL reset and beats every other event.
      if (state_q != StFail && sel_s_q != clkinsel_q) begin
         clkinsel_d = sel_s_q;
         state_d    = StReset;
         timer_d    = '0;
         pll_rst_d  = 1'b1;
         ready_d    = 1'b0;
      end else begin
         unique case (state_q)
            StReset: begin
               pll_rst_d = 1'b1;
               ready_d   = 1'b0;
               if (timer_q == RstLast) begin
                  state_d   = StWaitLock;
                  timer_d   = '0;
                  pll_rst_d = 1'b0;
               end else begin
                  timer_d = timer_q + TimerOne;
               end
            end
            StWaitLock: begin
               if (lk_s_q) begin
                  state_d = StStable;
                  timer_d = '0;
               end else if (timer_q == ToLast) begin
                  retry_d   = retry_sat;
                  timer_d   = '0;
                  pll_rst_d = 1'b1;
                  ready_d   = 1'b0;
                  if (MAX_RETRIES != 0 && {24'd0, retry_sat} >= MAX_RETRIES) begin
                     state_d = StFail;
                     fail_d  = 1'b1;
                  end else begin
                     state_d = StReset;
                  end
               end else begin
                  timer_d = timer_q + TimerOne;
               end
            end
            StStable: begin
               if (!lk_s_q) begin
                  state_d   = StReset;
                  timer_d   = '0;
                  pll_rst_d = 1'b1;
               end else if (timer_q == StbLast) begin
                  state_d = StRun;
                  timer_d = '0;
                  ready_d = 1'b1;
               end else begin
                  timer_d = timer_q + TimerOne;
               end
            end
            StRun: begin
               if (!lk_s_q) begin
                  loss_d    = loss_sat;
                  state_d   = StReset;
                  timer_d   = '0;
                  pll_rst_d = 1'b1;
                  ready_d   = 1'b0;
               end
            end
            StFail: begin
               pll_rst_d = 1'b1;
               ready_d   = 1'b0;
               fail_d    = 1'b1;
            end
            default: begin
               state_d   = StReset;
               timer_d   = '0;
               pll_rst_d = 1'b1;
               ready_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q    <= StReset;
         timer_q    <= '0;
         lk_meta_q  <= 1'b0;
         lk_s_q     <= 1'b0;
         sel_meta_q <= 1'b0;
         sel_s_q    <= 1'b0;
         pll_rst_q  <= 1'b1;
         clkinsel_q <= 1'b0;
         ready_q    <= 1'b0;
         user_rst_q <= 1'b1;
         fail_q     <= 1'b0;
         retry_q    <= 8'd0;
         loss_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         lk_meta_q  <= I_LOCKED;
         lk_s_q     <= lk_meta_q;
         sel_meta_q <= I_CLKINSEL;
         sel_s_q    <= sel_meta_q;
         pll_rst_q  <= pll_rst_d;
         clkinsel_q <= clkinsel_d;
         ready_q    <= ready_d;
         user_rst_q <= !ready_d;
         fail_q     <= fail_d;
         retry_q    <= retry_d;
         loss_q     <= loss_d;
      end
   end

   assign O_PLL_RST   = pll_rst_q;
   assign O_CLKINSEL  = clkinsel_q;
   assign O_READY     = ready_q;
   assign O_USER_RST  = user_rst_q;
   assign O_FAIL      = fail_q;
   assign O_RETRY_CNT = retry_q;
   assign O_LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario tasks plus randomized traffic, compared against a phase/elapsed-count model of the
// sequencer rules with explicit pipeline arrays standing in for the input synchronizers.
module tb_pll_reset_sequencer;

   localparam int RC = 4;
   localparam int TO = 50;
   localparam int LS = 8;
   localparam int MR = 3;

   localparam logic [20:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};

   logic       clk = 1'b0;
   logic       rstn, lk, sel;
   logic       o_pll_rst, o_clkinsel, o_ready, o_user_rst, o_fail;
   logic [7:0] o_retry, o_loss;
   logic [20:0] dut_vec;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .RST_CYCLES  (RC),
      .LOCK_TIMEOUT(TO),
      .LOCK_STABLE (LS),
      .MAX_RETRIES (MR)
   ) dut (
      .CLK        (clk),
      .RSTN       (rstn),
      .I_CLKINSEL (sel),
      .I_LOCKED   (lk),
      .O_PLL_RST  (o_pll_rst),
      .O_CLKINSEL (o_clkinsel),
      .O_READY    (o_ready),
      .O_USER_RST (o_user_rst),
      .O_FAIL     (o_fail),
      .O_RETRY_CNT(o_retry),
      .O_LOSS_CNT (o_loss)
   );

   assign dut_vec = {o_pll_rst, o_clkinsel, o_ready, o_user_rst, o_fail, o_retry, o_loss};

   // Reference model
   typedef enum {PhPulse, PhWait, PhQual, PhRun, PhDead} phase_t;
   phase_t m_phase;
   int     m_elapsed;
   bit     m_lk_pipe[2];
   bit     m_sel_pipe[2];
   bit     m_pll_rst, m_sel, m_ready, m_fail;
   int     m_retry, m_loss;

   function automatic logic [20:0] m_vec();
      return {m_pll_rst, m_sel, m_ready, !m_ready, m_fail, 8'(m_retry), 8'(m_loss)};
   endfunction

   task automatic m_restart();
      m_phase   = PhPulse;
      m_elapsed = 0;
      m_pll_rst = 1'b1;
      m_ready   = 1'b0;
   endtask

   task automatic model_step();
      bit lks, sels;
      if (!rstn) begin
         m_phase = PhPulse;
         m_elapsed = 0;
         m_lk_pipe[0] = 0; m_lk_pipe[1] = 0;
         m_sel_pipe[0] = 0; m_sel_pipe[1] = 0;
         m_pll_rst = 1; m_sel = 0; m_ready = 0; m_fail = 0;
         m_retry = 0; m_loss = 0;
         return;
      end
      lks = m_lk_pipe[1];
      sels = m_sel_pipe[1];
      m_lk_pipe[1] = m_lk_pipe[0];
      m_lk_pipe[0] = lk;
      m_sel_pipe[1] = m_sel_pipe[0];
      m_sel_pipe[0] = sel;
      if (m_phase != PhDead && sels != m_sel) begin
         m_sel = sels;
         m_restart();
         return;
      end
      case (m_phase)
         PhPulse: begin
            m_elapsed++;
            if (m_elapsed == RC) begin
               m_phase = PhWait;
               m_elapsed = 0;
               m_pll_rst = 0;
            end
         end
         PhWait: begin
            if (lks) begin
               m_phase = PhQual;
               m_elapsed = 0;
            end else begin
               m_elapsed++;
               if (m_elapsed == TO) begin
                  if (m_retry < 255) m_retry++;
                  if (MR != 0 && m_retry >= MR) begin
                     m_phase = PhDead;
                     m_fail = 1;
                     m_pll_rst = 1;
                     m_ready = 0;
                  end else begin
                     m_restart();
                  end
               end
            end
         end
         PhQual: begin
            if (!lks) m_restart();
            else begin
               m_elapsed++;
               if (m_elapsed == LS) begin
                  m_phase = PhRun;
                  m_ready = 1;
               end
            end
         end
         PhRun: begin
            if (!lks) begin
               if (m_loss < 255) m_loss++;
               m_restart();
            end
         end
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rstn = 0; lk = 0; sel = 0;
      tick();
      tick();
      rstn = 1;
   endtask

   task automatic test_reset();
      rstn = 0;
      for (int i = 0; i < 4; i++) begin
         lk = 1'($urandom % 2);
         sel = 1'($urandom % 2);
         tick();
         n_checks++;
         if (dut_vec !== RST_VEC) begin
            n_errors++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec, RST_VEC);
         end
      end
      lk = 0; sel = 0;
      tick();
      n_checks++;
      if (dut_vec !== m_vec()) begin
         n_errors++;
         $display("FAIL reset_model: got %h expected %h", dut_vec, m_vec());
      end
      rstn = 1;
   endtask

   task automatic test_normal_lock();
      bit exp_b;
      for (int e = 1; e <= 4; e++) begin
         tick();
         exp_b = (e < 4);
         n_checks++;
         if (o_pll_rst !== exp_b) begin
            n_errors++;
            $display("FAIL lock_rst_pulse edge %0d: got %b expected %b", e, o_pll_rst, exp_b);
         end
      end
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if (dut_vec !== m_vec()) begin
            n_errors++;
            $display("FAIL lock_wait_model: got %h expected %h", dut_vec, m_vec());
         end
      end
      lk = 1;
      for (int e = 1; e <= 11; e++) begin
         tick();
         exp_b = (e == 11);
         n_checks++;
         if (o_ready !== exp_b || o_user_rst !== !exp_b) begin
            n_errors++;
            $display("FAIL lock_ready edge %0d: got rdy=%b urst=%b expected rdy=%b", e, o_ready,
                     o_user_rst, exp_b);
         end
      end
   endtask

   task automatic test_lock_loss();
      bit exp_b;
      lk = 0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         n_checks++;
         if (e == 3) begin
            if (o_ready !== 0 || o_pll_rst !== 1 || o_loss !== 8'd1) begin
               n_errors++;
               $display("FAIL loss_edge: got rdy=%b rst=%b loss=%0d expected 0 1 1", o_ready,
                        o_pll_rst, o_loss);
            end
         end else if (o_ready !== 1) begin
            n_errors++;
            $display("FAIL loss_sync_delay edge %0d: got rdy=%b expected 1", e, o_ready);
         end
      end
      lk = 1;
      for (int e = 1; e <= 13; e++) begin
         tick();
         exp_b = (e == 13);
         n_checks++;
         if (o_ready !== exp_b || dut_vec !== m_vec()) begin
            n_errors++;
            $display("FAIL loss_relock edge %0d: got %h expected %h", e, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_clock_switch();
      sel = 1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         n_checks++;
         if (e == 3) begin
            if (o_clkinsel !== 1 || o_pll_rst !== 1 || o_ready !== 0 || o_retry !== 8'd0 ||
                o_loss !== 8'd1) begin
               n_errors++;
               $display("FAIL switch_edge: got %h expected sel=1 rst=1 rdy=0 retry=0 loss=1",
                        dut_vec);
            end
         end else if (o_clkinsel !== 0 || o_ready !== 1) begin
            n_errors++;
            $display("FAIL switch_sync edge %0d: got sel=%b rdy=%b expected 0 1", e, o_clkinsel,
                     o_ready);
         end
      end
      for (int e = 1; e <= 16; e++) begin
         if (e == 11) sel = 0;
         tick();
         n_checks++;
         if (e == 13 && (o_clkinsel !== 0 || o_pll_rst !== 1 || o_ready !== 0)) begin
            n_errors++;
            $display("FAIL switch_on_run_edge: got sel=%b rst=%b rdy=%b expected 0 1 0",
                     o_clkinsel, o_pll_rst, o_ready);
         end else if (dut_vec !== m_vec() || (e >= 12 && o_ready !== 0)) begin
            n_errors++;
            $display("FAIL switch_model edge %0d: got %h expected %h", e, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_glitch();
      int  ones;
      bit  saw_ready;
      ones = 0;
      saw_ready = 0;
      do_reset();
      for (int e = 0; e < 6; e++) tick();
      lk = 1;
      for (int e = 0; e < 5; e++) begin
         tick();
         saw_ready |= (o_ready === 1'b1);
      end
      lk = 0;
      for (int e = 0; e < 20; e++) begin
         tick();
         saw_ready |= (o_ready === 1'b1);
         if (o_pll_rst === 1'b1) ones++;
         n_checks++;
         if (dut_vec !== m_vec()) begin
            n_errors++;
            $display("FAIL glitch_model: got %h expected %h", dut_vec, m_vec());
         end
      end
      n_checks++;
      if (ones != RC || saw_ready || o_loss !== 8'd0) begin
         n_errors++;
         $display("FAIL glitch_summary: got pulse=%0d ready_seen=%b loss=%0d expected 4 0 0",
                  ones, saw_ready, o_loss);
      end
   endtask

   task automatic test_timeout_fail();
      do_reset();
      for (int t = 1; t <= 3 * (RC + TO); t++) begin
         tick();
         n_checks++;
         if (dut_vec !== m_vec()) begin
            n_errors++;
            $display("FAIL timeout_model t=%0d: got %h expected %h", t, dut_vec, m_vec());
         end
         if (t % (RC + TO) == 0 || t % (RC + TO) == RC + TO - 1) begin
            n_checks++;
            if (o_retry !== 8'(t / (RC + TO))) begin
               n_errors++;
               $display("FAIL timeout_retry t=%0d: got %0d expected %0d", t, o_retry,
                        t / (RC + TO));
            end
         end
      end
      sel = 1;
      for (int e = 0; e < 20; e++) begin
         tick();
         n_checks++;
         if (o_fail !== 1 || o_pll_rst !== 1 || o_clkinsel !== 0 || o_retry !== 8'd3 ||
             o_ready !== 0) begin
            n_errors++;
            $display("FAIL fail_sticky: got %h expected rst=1 sel=0 rdy=0 fail=1 retry=3",
                     dut_vec);
         end
      end
      rstn = 0;
      tick();
      n_checks++;
      if (dut_vec !== RST_VEC) begin
         n_errors++;
         $display("FAIL fail_clear: got %h expected %h", dut_vec, RST_VEC);
      end
      sel = 0;
      rstn = 1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      sel = 1;
      for (int t = 0; t < 70; t++) tick();
      n_checks++;
      if (o_clkinsel !== 1 || o_retry !== 8'd1 || dut_vec !== m_vec()) begin
         n_errors++;
         $display("FAIL mid_setup: got %h expected %h", dut_vec, m_vec());
      end
      rstn = 0;
      tick();
      n_checks++;
      if (dut_vec !== RST_VEC) begin
         n_errors++;
         $display("FAIL mid_reset: got %h expected %h", dut_vec, RST_VEC);
      end
      sel = 0;
      rstn = 1;
   endtask

   task automatic test_random();
      int periods[4] = '{3, 8, 20, 60};
      int period;
      for (int r = 0; r < 6; r++) begin
         period = periods[$urandom_range(0, 3)];
         do_reset();
         sel = 1'($urandom % 2);
         for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, period - 1) == 0) lk = ~lk;
            if ($urandom_range(0, 299) == 0) sel = ~sel;
            rstn = ($urandom_range(0, 999) != 0);
            tick();
            n_checks++;
            if (dut_vec !== m_vec()) begin
               n_errors++;
               $display("FAIL random_model round %0d cyc %0d: got %h expected %h", r, c,
                        dut_vec, m_vec());
            end
         end
      end
      rstn = 1;
   endtask

   initial begin
      rstn = 0; lk = 0; sel = 0;
      test_reset();
      test_normal_lock();
      test_lock_loss();
      test_clock_switch();
      test_glitch();
      test_timeout_fail();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
